// File: rtl/mem_ctrl_uart_arb.sv
// Multi-channel UART memory controller: per-channel request FIFOs, round-robin
// arbitration, 7-bit-segment frame serialisation and read-reply collection with timeout.
module mem_ctrl_uart_arb #(
  parameter int NCH      = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int QDEPTH_L = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          c_req,
  input  logic [NCH-1:0]          c_rw,
  input  logic [2*NCH-1:0]        c_len,
  input  logic [ADDR_W*NCH-1:0]   c_addr,
  input  logic [DATA_W*NCH-1:0]   c_wdata,
  output logic [NCH-1:0]          c_ready,
  output logic [DATA_W-1:0]       c_rdata,
  output logic [NCH-1:0]          c_rvalid,
  output logic [NCH-1:0]          c_wdone,
  output logic [NCH-1:0]          c_err,
  output logic [7:0]              u_tx_data,
  output logic                    u_tx_valid,
  input  logic                    u_tx_ready,
  input  logic [7:0]              u_rx_data,
  input  logic                    u_rx_valid,
  output logic                    u_rx_ready
);

  localparam int NA    = ADDR_W / 8;
  localparam int DEPTH = 1 << QDEPTH_L;
  localparam int PW    = (QDEPTH_L > 0) ? QDEPTH_L : 1;
  localparam int CW    = QDEPTH_L + 1;
  localparam int GW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW    = 3 + ADDR_W + DATA_W;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int KW    = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_AMSB, S_WDATA, S_WMSB, S_RDATA
  } state_t;

  // Byte presented on the link for a given tx state and segment index.
  function automatic logic [7:0] tx_byte(input state_t st, input logic [KW-1:0] k,
                                         input logic rw, input logic [1:0] len,
                                         input logic [ADDR_W-1:0] a,
                                         input logic [DATA_W-1:0] d);
    logic [7:0]        b;
    logic [ADDR_W-1:0] as;
    logic [DATA_W-1:0] ds;
    b  = 8'h00;
    as = a >> (8 * k);
    ds = d >> (8 * k);
    case (st)
      S_HDR:   b = {1'b1, rw, 4'b0000, len};
      S_ADDR:  b = {1'b0, as[6:0]};
      S_AMSB:  for (int j = 0; j < NA; j++) b[j] = a[8*j+7];
      S_WDATA: b = {1'b0, ds[6:0]};
      S_WMSB:  for (int j = 0; j < DATA_W / 8; j++) b[j] = (j <= int'(len)) ? d[8*j+7] : 1'b0;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [EW-1:0]  head_s [NCH];
  logic [NCH-1:0] nonempty_s;
  logic [NCH-1:0] pop_s;

  for (genvar i = 0; i < NCH; i++) begin : g_fifo
    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic          rdy_r;
    logic          push_s;

    // The registered not-full flag gates pushes, so a full FIFO never accepts a push.
    assign push_s        = c_req[i] & rdy_r;
    assign c_ready[i]    = rdy_r;
    assign nonempty_s[i] = (cnt_r != '0);
    assign head_s[i]     = mem_r[rd_ptr_r];

    // Occupancy after this edge's push and pop.
    always_comb begin
      cnt_next_s = cnt_r;
      if (push_s && !pop_s[i]) cnt_next_s = cnt_r + CW'(1);
      else if (pop_s[i] && !push_s) cnt_next_s = cnt_r - CW'(1);
      else cnt_next_s = cnt_r;
    end

    // FIFO pointers, count and ready flag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        cnt_r    <= '0;
        rdy_r    <= 1'b1;
      end else begin
        if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (pop_s[i]) rd_ptr_r <= ptr_inc(rd_ptr_r);
        cnt_r <= cnt_next_s;
        rdy_r <= (cnt_next_s != CW'(DEPTH));
      end
    end

    // Entry storage, written as {rw, len, addr, wdata}.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {c_rw[i], c_len[2*i +: 2], c_addr[ADDR_W*i +: ADDR_W],
                            c_wdata[DATA_W*i +: DATA_W]};
      end
    end
  end

  state_t            state_r, state_next;
  logic [KW-1:0]     k_r, k_next;
  logic [GW-1:0]     ch_r, ch_next, last_r, last_next, grant_s;
  logic              rw_r, rw_next;
  logic [1:0]        len_r, len_next;
  logic [ADDR_W-1:0] addr_r, addr_next;
  logic [DATA_W-1:0] wdata_r, wdata_next;
  logic [DATA_W-1:0] rbuf_r, rbuf_next;
  logic [TW-1:0]     tmo_r, tmo_next;
  logic [7:0]        tx_data_r, tx_data_next;
  logic              tx_valid_r, tx_valid_next;
  logic [DATA_W-1:0] rdata_r;
  logic [NCH-1:0]    rvalid_r, wdone_r, err_r;
  logic              found_s, hs_s, rd_done_s, wr_done_s, tmo_err_s;

  assign hs_s       = tx_valid_r & u_tx_ready;
  assign u_tx_data  = tx_data_r;
  assign u_tx_valid = tx_valid_r;
  assign u_rx_ready = 1'b1;
  assign c_rdata    = rdata_r;
  assign c_rvalid   = rvalid_r;
  assign c_wdone    = wdone_r;
  assign c_err      = err_r;

  // Arbitration, frame sequencing, reply collection and next tx byte.
  always_comb begin
    state_next = state_r;
    k_next     = k_r;
    ch_next    = ch_r;
    last_next  = last_r;
    rw_next    = rw_r;
    len_next   = len_r;
    addr_next  = addr_r;
    wdata_next = wdata_r;
    rbuf_next  = rbuf_r;
    tmo_next   = tmo_r;
    pop_s      = '0;
    found_s    = 1'b0;
    grant_s    = '0;
    rd_done_s  = 1'b0;
    wr_done_s  = 1'b0;
    tmo_err_s  = 1'b0;

    for (int off = 1; off <= NCH; off++) begin
      int idx;
      idx = (int'(last_r) + off) % NCH;
      if (!found_s && nonempty_s[idx]) begin
        found_s = 1'b1;
        grant_s = GW'(idx);
      end else begin
        found_s = found_s;
      end
    end

    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          state_next   = S_HDR;
          k_next       = '0;
          ch_next      = grant_s;
          last_next    = grant_s;
          pop_s[grant_s] = 1'b1;
          {rw_next, len_next, addr_next, wdata_next} = head_s[grant_s];
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HDR: begin
        if (hs_s) begin
          state_next = S_ADDR;
          k_next     = '0;
        end else begin
          state_next = S_HDR;
        end
      end
      S_ADDR: begin
        if (hs_s && (k_r == KW'(NA - 1))) begin
          state_next = S_AMSB;
          k_next     = '0;
        end else if (hs_s) begin
          k_next = k_r + KW'(1);
        end else begin
          k_next = k_r;
        end
      end
      S_AMSB: begin
        if (hs_s) begin
          state_next = rw_r ? S_RDATA : S_WDATA;
          k_next     = '0;
          rbuf_next  = '0;
          tmo_next   = '0;
        end else begin
          state_next = S_AMSB;
        end
      end
      S_WDATA: begin
        if (hs_s && (k_r == {1'b0, len_r})) begin
          state_next = S_WMSB;
          k_next     = '0;
        end else if (hs_s) begin
          k_next = k_r + KW'(1);
        end else begin
          k_next = k_r;
        end
      end
      S_WMSB: begin
        if (hs_s) begin
          state_next = S_IDLE;
          wr_done_s  = 1'b1;
        end else begin
          state_next = S_WMSB;
        end
      end
      S_RDATA: begin
        if (u_rx_valid) begin
          rbuf_next = rbuf_r | (DATA_W'(u_rx_data) << (8 * k_r));
          tmo_next  = '0;
          if (k_r == {1'b0, len_r}) begin
            state_next = S_IDLE;
            rd_done_s  = 1'b1;
          end else begin
            k_next = k_r + KW'(1);
          end
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          state_next = S_IDLE;
          tmo_err_s  = 1'b1;
        end else begin
          tmo_next = tmo_r + TW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    tx_valid_next = (state_next != S_IDLE) && (state_next != S_RDATA);
    tx_data_next  = tx_byte(state_next, k_next, rw_next, len_next, addr_next, wdata_next);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      k_r        <= '0;
      ch_r       <= '0;
      last_r     <= GW'(NCH - 1);
      rw_r       <= 1'b0;
      len_r      <= 2'b00;
      addr_r     <= '0;
      wdata_r    <= '0;
      rbuf_r     <= '0;
      tmo_r      <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      rdata_r    <= '0;
      rvalid_r   <= '0;
      wdone_r    <= '0;
      err_r      <= '0;
    end else begin
      state_r    <= state_next;
      k_r        <= k_next;
      ch_r       <= ch_next;
      last_r     <= last_next;
      rw_r       <= rw_next;
      len_r      <= len_next;
      addr_r     <= addr_next;
      wdata_r    <= wdata_next;
      rbuf_r     <= rbuf_next;
      tmo_r      <= tmo_next;
      tx_data_r  <= tx_data_next;
      tx_valid_r <= tx_valid_next;
      if (rd_done_s) rdata_r <= rbuf_next;
      rvalid_r   <= rd_done_s ? (NCH'(1) << ch_r) : '0;
      wdone_r    <= wr_done_s ? (NCH'(1) << ch_r) : '0;
      err_r      <= tmo_err_s ? (NCH'(1) << ch_r) : '0;
    end
  end

endmodule

// File: doc/mem_ctrl_uart_arb.md
# mem_ctrl_uart_arb

Parametrised, fully synchronous successor to the single-port UART memory controller (north bridge). It serves `NCH` client ports, each with its own request FIFO, and arbitrates between them round-robin. Each request is serialised into the 7-bit-segment byte protocol on the UART byte link. Read replies return as raw bytes and are checked against a reply timeout.

## Interface
Parameters:
- `NCH`, 2: client channel count (1..4).
- `ADDR_W`, 32: address width; multiple of 8, 16..56.
- `DATA_W`, 32: data width; 32 only for this revision (len field is 2 bits).
- `QDEPTH_L`, 2: log2 of per-channel FIFO depth.
- `TIMEOUT`, 4096: maximum idle cycles between read-reply bytes.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `c_req` in NCH: per-channel request push strobe. The push is accepted on an edge where `c_req[i] & c_ready[i]`.
- `c_rw` in NCH: 1 = read, 0 = write.
- `c_len` in 2*NCH: bytes-1 (0..3).
- `c_addr` in ADDR_W*NCH: byte address.
- `c_wdata` in DATA_W*NCH: write data, byte 0 in [7:0].
- `c_ready` out NCH: FIFO not full.
- `c_rdata` out DATA_W: shared read-return bus.
- `c_rvalid` out NCH: one-cycle read-done pulse; qualifies `c_rdata`.
- `c_wdone` out NCH: one-cycle write-done pulse.
- `c_err` out NCH: one-cycle read-timeout pulse.
- `u_tx_data` out 8: byte to UART.
- `u_tx_valid` out 1: byte valid.
- `u_tx_ready` in 1: UART accepts byte.
- `u_rx_data` in 8: byte from UART.
- `u_rx_valid` in 1: byte valid.
- `u_rx_ready` out 1: constant 1; the controller never stalls rx.

## Operation
- FIFO entry format: {rw, len, addr, wdata}. A push while full is ignored. `c_ready` goes low on the edge that fills the FIFO.
- Arbiter: in IDLE, grants the lowest channel index ≥ last_grant+1 (mod NCH) whose FIFO is non-empty. The granted entry is popped into working registers on the grant edge. last_grant resets to NCH-1, so channel 0 wins first.
- Frame layout, sent byte-by-byte:
  - Header: read = {6'b110000, len}, write = {6'b100000, len}.
  - Address: ADDR_W/8 segments, each {1'b0, addr[8k+6:8k]}, k ascending.
  - Address MSB byte: bit k = addr[8k+7], unused bits 0.
  - Write data: len+1 data segments {1'b0, wdata[8k+6:8k]}, then a data MSB byte with bit k = wdata[8k+7].
- States:
  - IDLE → HDR on grant.
  - HDR → ADDR → AMSB.
  - AMSB → WDATA (write) or RDATA (read).
  - WDATA → WMSB → IDLE.
  - RDATA → IDLE.
- Every tx state advances only on `u_tx_valid & u_tx_ready`. The segment counter k resets to 0 on each entry.
- RDATA: collects len+1 bytes. byte k lands in `c_rdata[8k+7:8k]`; bytes above len are 0.
- Timeout: a counter clears on entry to RDATA and on every rx byte. It increments otherwise. At TIMEOUT-1 the block pulses `c_err[ch]`, discards the partial data and returns to IDLE.
- rx bytes outside RDATA are accepted and dropped.
- len > DATA_W/8-1 cannot occur (2-bit field, DATA_W = 32).

## Timing
- Reset values: `c_ready` all 1; all other outputs 0 except `u_rx_ready` = 1. All FIFOs are empty, state = IDLE, last_grant = NCH-1.
- Reset mid-frame abandons the frame with no done or err pulse. Queued requests are lost.
- Idle latency: push accepted at edge t → grant at edge t+1 → header on `u_tx_data` with `u_tx_valid` = 1 after edge t+1. This is 2 cycles.
- `u_tx_data` and `u_tx_valid` stay stable while `u_tx_ready` = 0.
- Write: `c_wdone[ch]` pulses the cycle after the data MSB byte handshake. The next grant is possible at that same edge.
- Read: `c_rvalid[ch]` pulses the cycle after the last reply byte. `c_rdata` holds its value until the next read completes.
- Simultaneous push and pop on one FIFO are both honoured. A full FIFO does not accept a push in the same cycle it is popped; `c_ready` is a registered not-full.
- A FIFO of depth 1 (QDEPTH_L = 0) is legal.

## Test plan
- Write, ch0, addr 0x80001234, wdata 0x000000FF, len 0 → tx 0x80, 0x34, 0x12, 0x00, 0x00, 0x08, 0x7F, 0x01. `c_wdone[0]` pulses once.
- Read, ch1, addr 0x00000010, len 3 → tx 0xC3, 0x10, 0x00, 0x00, 0x00, 0x00. Drive rx 0xAA, 0xBB, 0xCC, 0xDD → `c_rdata` = 0xDDCCBBAA and `c_rvalid` = 2'b10 for 1 cycle.
- Arbitration: ch0 pushes 2 writes and ch1 pushes 1 write on the same edge → frame order ch0, ch1, ch0.
- Backpressure: hold `u_tx_ready` = 0 for 5 cycles mid-address → byte unchanged and no skipped or duplicated segment.
- TIMEOUT = 16: read with no reply → `c_err` pulses 16 cycles after the AMSB handshake. A following queued write then completes normally.
- QDEPTH_L = 2: 5 back-to-back pushes on ch0 while tx is stalled → `c_ready[0]` drops after the 4th push and the 5th push is dropped. Assert `rst` mid-frame → all outputs return to their reset values and `u_tx_valid` = 0.
